cpu_test_monitor: RTL and testbench
===================================

# cpu_test_monitor

Synthesizable self-checking monitor for the pipelined 16-bit CPU, driven by the same observation signals the simulation bench uses: `num_inst`, `output_port` and `is_halted`. It holds a loadable table of NUM_TEST checkpoints, each an instruction count paired with the expected WWD value, and grades each checkpoint as the CPU runs. It stops on halt or on a cycle budget, then scans the table to produce a pass summary. It sits beside the CPU on FPGA builds, so regression results are visible without a simulator.

## Interface
- WORD_SIZE, 16, width of num_inst, output_port, answers and cycle counter
- NUM_TEST, 56, checkpoint table depth (≥1)
- MAX_CYCLES, 10000, cycle budget per run before forced end
- IDX_W, $clog2(NUM_TEST), table index width
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  pulse in IDLE to begin a run
- load_en  in  1  write table entry (honoured in IDLE only)
- load_idx  in  IDX_W  entry written
- load_num_inst  in  WORD_SIZE  checkpoint instruction count
- load_ans  in  WORD_SIZE  expected output_port
- num_inst  in  WORD_SIZE  CPU retired-instruction count
- output_port  in  WORD_SIZE  CPU WWD output
- is_halted  in  1  CPU halt flag
- busy  out  1  RUN or SUMMARY
- done  out  1  summary valid, held until next start
- all_pass  out  1  pass_count == NUM_TEST
- pass_count  out  IDX_W+1  checkpoints passed
- fail_valid  out  1  at least one checkpoint wrong
- fail_idx  out  IDX_W  first wrong checkpoint
- fail_value  out  WORD_SIZE  output_port captured at first failure
- timed_out  out  1  run ended by MAX_CYCLES
- cycle_count  out  WORD_SIZE  cycles spent in RUN

## Operation
- FSM states: IDLE → RUN → SUMMARY → DONE. From DONE, a start pulse returns to RUN. Only reset clears the table.
- IDLE: load_en writes the table entry; loaded entries must have num_inst strictly ascending by index. A start pulse clears every status to NO_RESULT and clears ptr, cycle_count, fail_*, timed_out, done and pass_count. If load_en and start arrive in the same cycle, the load is applied and the run starts the next cycle.
- Status per entry, 2 bits: NO_RESULT=0, PASS=1, WRONG=2.
- RUN, each cycle, with ptr as the current entry:
  - If num_inst == exp[ptr] and output_port == ans[ptr]: status becomes PASS, unless it is already WRONG.
  - If num_inst == exp[ptr] and the values mismatch: status becomes WRONG (sticky). If fail_valid is clear, capture fail_idx=ptr and fail_value=output_port, then set fail_valid.
  - If num_inst > exp[ptr]: ptr advances by one. The entry keeps its status, so a skipped entry stays NO_RESULT.
  - ptr saturates at NUM_TEST-1.
- RUN exits to SUMMARY when either condition holds:
  - is_halted=1: the same-cycle comparison is still applied.
  - cycle_count == MAX_CYCLES-1: timed_out is set.
- SUMMARY: scans entries 0..NUM_TEST-1, one per cycle, incrementing pass_count for each PASS. Then it moves to DONE, where done=1.
- Comparison is unsigned equality. cycle_count saturates at all-ones.

## Timing
- Reset values of all outputs: 0. The table contents are cleared to 0 and all statuses set to NO_RESULT.
- Reset asserted mid-run aborts the run and returns the FSM to IDLE on the next edge.
- A start pulse in cycle t gives busy=1 from cycle t+1.
- Table inputs are sampled at posedge. Status and fail_* updates are visible the cycle after the compare.
- SUMMARY takes exactly NUM_TEST cycles. done rises NUM_TEST+1 cycles after RUN exits.
- all_pass and pass_count are valid only while done=1.
- start is ignored while busy.

## Configuration
- `CPU_TEST_MONITOR_STOP_ON_FAIL_EN`
  - Defined: the first WRONG compare ends RUN in the same cycle, as if halted. Remaining entries stay NO_RESULT.
  - Undefined: RUN continues after failures, and only is_halted or the timeout end it. fail_* still report the first failure.

## Structure
- Package `cpu_test_pkg` holds the status encoding (NO_RESULT/PASS/WRONG), the FSM state encoding and the default WORD_SIZE/NUM_TEST/MAX_CYCLES constants.
- Sub-module `cpu_test_table` is the NUM_TEST-entry register file. It has:
  - a write port for loading;
  - one read port at ptr for the compare;
  - one read port at the scan index for SUMMARY;
  - per-entry status write and clear-all.

## Test plan
- Load 3 entries {(3,0x0000),(5,0x0001),(7,0x0002)}. Drive num_inst 0..7 with matching output_port, then is_halted at 8. Required: pass_count=3, all_pass=1, fail_valid=0.
- Same table, but output_port=0x00FF while num_inst=5, without STOP_ON_FAIL. Required: fail_idx=1, fail_value=0x00FF, pass_count=2.
- Same as the previous case, with STOP_ON_FAIL defined. Required: RUN ends at num_inst=5, and entry 2 is NO_RESULT with pass_count=1.
- Jump num_inst from 4 to 6, skipping 5. Required: entry 1 stays NO_RESULT, entry 2 passes and pass_count=2.
- Never assert is_halted, with MAX_CYCLES=20. Required: timed_out=1, cycle_count=19 and done=1 after NUM_TEST+1 more cycles.
- Pull reset_n low mid-RUN. Required: all outputs 0 at the next edge; after reloading and a new start, the run grades from a clean state.

Source files
------------

// File: rtl/cpu_test_pkg.sv
`default_nettype none
// ============================================================================
// cpu_test_pkg : shared encodings and defaults for the CPU test monitor
// Revision 1.0
// ============================================================================
package cpu_test_pkg;

  localparam int unsigned c_word_size  = 16;
  localparam int unsigned c_num_test   = 56;
  localparam int unsigned c_max_cycles = 10000;

  typedef logic [1:0] status_t;

  localparam status_t c_no_result = 2'd0;
  localparam status_t c_pass      = 2'd1;
  localparam status_t c_wrong     = 2'd2;

  localparam logic [1:0] c_s_idle    = 2'd0;
  localparam logic [1:0] c_s_run     = 2'd1;
  localparam logic [1:0] c_s_summary = 2'd2;
  localparam logic [1:0] c_s_done    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/cpu_test_table.sv
`default_nettype none
// ============================================================================
// cpu_test_table : checkpoint register file with a load port, compare and
// scan read ports, and per-entry grading status
// Revision 1.0
// ============================================================================
module cpu_test_table
  import cpu_test_pkg::*;
#(
  parameter int WORD_SIZE = c_word_size,
  parameter int NUM_TEST  = c_num_test,
  parameter int IDX_W     = (NUM_TEST > 1) ? $clog2(NUM_TEST) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_wr_en,
  input  logic [IDX_W-1:0]     i_wr_idx,
  input  logic [WORD_SIZE-1:0] i_wr_exp,
  input  logic [WORD_SIZE-1:0] i_wr_ans,
  input  logic [IDX_W-1:0]     i_rd_idx,
  output logic [WORD_SIZE-1:0] o_rd_exp,
  output logic [WORD_SIZE-1:0] o_rd_ans,
  output status_t              o_rd_status,
  input  logic [IDX_W-1:0]     i_scan_idx,
  output status_t              o_scan_status,
  input  logic                 i_st_wr_en,
  input  logic [IDX_W-1:0]     i_st_idx,
  input  status_t              i_st_val,
  input  logic                 i_st_clr
);

  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_TEST - 1);

  logic [WORD_SIZE-1:0] r_exp    [NUM_TEST];
  logic [WORD_SIZE-1:0] r_ans    [NUM_TEST];
  status_t              r_status [NUM_TEST];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_TEST; i++) begin
        r_exp[i] <= '0;
        r_ans[i] <= '0;
      end
    end else if (i_wr_en && (i_wr_idx <= c_idx_last)) begin
      r_exp[i_wr_idx] <= i_wr_exp;
      r_ans[i_wr_idx] <= i_wr_ans;
    end
  end

  // Clear-all takes priority; it only coincides with a run start.
  always_ff @(posedge clk) begin
    if (!reset_n || i_st_clr) begin
      for (int i = 0; i < NUM_TEST; i++) begin
        r_status[i] <= c_no_result;
      end
    end else if (i_st_wr_en && (i_st_idx <= c_idx_last)) begin
      r_status[i_st_idx] <= i_st_val;
    end
  end

  assign o_rd_exp      = r_exp[i_rd_idx];
  assign o_rd_ans      = r_ans[i_rd_idx];
  assign o_rd_status   = r_status[i_rd_idx];
  assign o_scan_status = r_status[i_scan_idx];

endmodule
`default_nettype wire

// File: rtl/cpu_test_monitor.sv
`default_nettype none
// ============================================================================
// cpu_test_monitor : grades CPU checkpoints (num_inst, output_port) at run
// time and summarises the result. Option: CPU_TEST_MONITOR_STOP_ON_FAIL_EN
// Revision 1.0
// ============================================================================
module cpu_test_monitor
  import cpu_test_pkg::*;
#(
  parameter int WORD_SIZE  = c_word_size,
  parameter int NUM_TEST   = c_num_test,
  parameter int MAX_CYCLES = c_max_cycles,
  parameter int IDX_W      = (NUM_TEST > 1) ? $clog2(NUM_TEST) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 load_en,
  input  logic [IDX_W-1:0]     load_idx,
  input  logic [WORD_SIZE-1:0] load_num_inst,
  input  logic [WORD_SIZE-1:0] load_ans,
  input  logic [WORD_SIZE-1:0] num_inst,
  input  logic [WORD_SIZE-1:0] output_port,
  input  logic                 is_halted,
  output logic                 busy,
  output logic                 done,
  output logic                 all_pass,
  output logic [IDX_W:0]       pass_count,
  output logic                 fail_valid,
  output logic [IDX_W-1:0]     fail_idx,
  output logic [WORD_SIZE-1:0] fail_value,
  output logic                 timed_out,
  output logic [WORD_SIZE-1:0] cycle_count
);

  localparam logic [IDX_W-1:0]     c_idx_last  = IDX_W'(NUM_TEST - 1);
  localparam logic [WORD_SIZE-1:0] c_cyc_last  = WORD_SIZE'(MAX_CYCLES - 1);
  localparam logic [IDX_W:0]       c_pass_full = (IDX_W + 1)'(NUM_TEST);

  logic [1:0]           r_state;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_scan;
  logic [WORD_SIZE-1:0] r_cycle;
  logic [IDX_W:0]       r_pass_count;
  logic                 r_fail_valid;
  logic [IDX_W-1:0]     r_fail_idx;
  logic [WORD_SIZE-1:0] r_fail_value;
  logic                 r_timed_out;
  logic                 r_done;

  logic [WORD_SIZE-1:0] w_rd_exp;
  logic [WORD_SIZE-1:0] w_rd_ans;
  status_t              w_rd_status;
  status_t              w_scan_status;
  logic                 w_in_run;
  logic                 w_in_idle;
  logic                 w_start_ok;
  logic                 w_hit;
  logic                 w_match;
  logic                 w_past;
  logic                 w_wrong;
  logic                 w_timeout;
  logic                 w_stop_fail;
  logic                 w_run_exit;
  logic                 w_st_wr_en;
  status_t              w_st_val;

  assign w_in_run   = (r_state == c_s_run);
  assign w_in_idle  = (r_state == c_s_idle);
  assign w_start_ok = start && (w_in_idle || (r_state == c_s_done));

  assign w_hit     = (num_inst == w_rd_exp);
  assign w_match   = (output_port == w_rd_ans);
  assign w_past    = (num_inst > w_rd_exp);
  assign w_wrong   = w_in_run && w_hit && !w_match;
  assign w_timeout = (r_cycle == c_cyc_last);

`ifdef CPU_TEST_MONITOR_STOP_ON_FAIL_EN
  assign w_stop_fail = w_wrong;
`else
  assign w_stop_fail = 1'b0;
`endif

  assign w_run_exit = w_in_run && (is_halted || w_timeout || w_stop_fail);

  // WRONG is sticky: a later matching compare must not upgrade it to PASS.
  assign w_st_wr_en = w_in_run && w_hit && (!w_match || (w_rd_status != c_wrong));
  assign w_st_val   = w_match ? c_pass : c_wrong;

  cpu_test_table #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_TEST  (NUM_TEST),
    .IDX_W     (IDX_W)
  ) u_table (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_wr_en       (load_en && w_in_idle),
    .i_wr_idx      (load_idx),
    .i_wr_exp      (load_num_inst),
    .i_wr_ans      (load_ans),
    .i_rd_idx      (r_ptr),
    .o_rd_exp      (w_rd_exp),
    .o_rd_ans      (w_rd_ans),
    .o_rd_status   (w_rd_status),
    .i_scan_idx    (r_scan),
    .o_scan_status (w_scan_status),
    .i_st_wr_en    (w_st_wr_en),
    .i_st_idx      (r_ptr),
    .i_st_val      (w_st_val),
    .i_st_clr      (w_start_ok)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= c_s_idle;
      r_ptr        <= '0;
      r_scan       <= '0;
      r_cycle      <= '0;
      r_pass_count <= '0;
      r_fail_valid <= 1'b0;
      r_fail_idx   <= '0;
      r_fail_value <= '0;
      r_timed_out  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        c_s_idle, c_s_done: begin
          if (w_start_ok) begin
            r_state      <= c_s_run;
            r_ptr        <= '0;
            r_scan       <= '0;
            r_cycle      <= '0;
            r_pass_count <= '0;
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
            r_fail_value <= '0;
            r_timed_out  <= 1'b0;
            r_done       <= 1'b0;
          end
        end
        c_s_run: begin
          if (w_past && (r_ptr != c_idx_last)) begin
            r_ptr <= r_ptr + 1'b1;
          end
          if (w_wrong && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_idx   <= r_ptr;
            r_fail_value <= output_port;
          end
          // The exit cycle is not counted, so a timeout leaves MAX_CYCLES-1.
          if (w_run_exit) begin
            r_state     <= c_s_summary;
            r_timed_out <= w_timeout;
            r_scan      <= '0;
          end else if (r_cycle != '1) begin
            r_cycle <= r_cycle + 1'b1;
          end
        end
        c_s_summary: begin
          if (w_scan_status == c_pass) begin
            r_pass_count <= r_pass_count + 1'b1;
          end
          if (r_scan == c_idx_last) begin
            r_state <= c_s_done;
            r_done  <= 1'b1;
          end else begin
            r_scan <= r_scan + 1'b1;
          end
        end
        default: r_state <= c_s_idle;
      endcase
    end
  end

  assign busy        = w_in_run || (r_state == c_s_summary);
  assign done        = r_done;
  assign all_pass    = r_done && (r_pass_count == c_pass_full);
  assign pass_count  = r_pass_count;
  assign fail_valid  = r_fail_valid;
  assign fail_idx    = r_fail_idx;
  assign fail_value  = r_fail_value;
  assign timed_out   = r_timed_out;
  assign cycle_count = r_cycle;

endmodule
`default_nettype wire

// File: tb/tb_cpu_test_monitor.sv
`default_nettype none
// ============================================================================
// tb_cpu_test_monitor : directed self-checking bench for cpu_test_monitor
// Revision 1.0
// ============================================================================
module tb_cpu_test_monitor;

  localparam int WORD_SIZE  = 16;
  localparam int NUM_TEST   = 3;
  localparam int MAX_CYCLES = 20;
  localparam int IDX_W      = 2;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 start;
  logic                 load_en;
  logic [IDX_W-1:0]     load_idx;
  logic [WORD_SIZE-1:0] load_num_inst;
  logic [WORD_SIZE-1:0] load_ans;
  logic [WORD_SIZE-1:0] num_inst;
  logic [WORD_SIZE-1:0] output_port;
  logic                 is_halted;
  logic                 busy;
  logic                 done;
  logic                 all_pass;
  logic [IDX_W:0]       pass_count;
  logic                 fail_valid;
  logic [IDX_W-1:0]     fail_idx;
  logic [WORD_SIZE-1:0] fail_value;
  logic                 timed_out;
  logic [WORD_SIZE-1:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WORD_SIZE-1:0] seq_ni [16];
  logic [WORD_SIZE-1:0] seq_op [16];

  always #5 clk = ~clk;

  cpu_test_monitor #(
    .WORD_SIZE  (WORD_SIZE),
    .NUM_TEST   (NUM_TEST),
    .MAX_CYCLES (MAX_CYCLES),
    .IDX_W      (IDX_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .load_en       (load_en),
    .load_idx      (load_idx),
    .load_num_inst (load_num_inst),
    .load_ans      (load_ans),
    .num_inst      (num_inst),
    .output_port   (output_port),
    .is_halted     (is_halted),
    .busy          (busy),
    .done          (done),
    .all_pass      (all_pass),
    .pass_count    (pass_count),
    .fail_valid    (fail_valid),
    .fail_idx      (fail_idx),
    .fail_value    (fail_value),
    .timed_out     (timed_out),
    .cycle_count   (cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [WORD_SIZE-1:0] ans_for(input int k);
    case (k)
      3:       return 16'h0000;
      5:       return 16'h0001;
      7:       return 16'h0002;
      default: return 16'h1234;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; start = 1'b0; load_en = 1'b0; load_idx = '0;
    load_num_inst = '0; load_ans = '0; num_inst = '0; output_port = '0;
    is_halted = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic load(input int idx, input int e, input int a);
    @(negedge clk);
    load_en = 1'b1; load_idx = IDX_W'(idx);
    load_num_inst = WORD_SIZE'(e); load_ans = WORD_SIZE'(a);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic load_std();
    load(0, 3, 0);
    load(1, 5, 1);
    load(2, 7, 2);
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 9; i++) begin
      seq_ni[i] = WORD_SIZE'(i);
      seq_op[i] = ans_for(i);
    end
  endtask

  // Start pulse, then one table row per cycle; halt rides on the last row.
  task automatic run_seq(input int n, input bit halt_last);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 0) check("busy_after_start", 32'(busy), 32'd1);
      num_inst    = seq_ni[i];
      output_port = seq_op[i];
      is_halted   = halt_last && (i == n - 1);
    end
    @(negedge clk);
    is_halted = 1'b0;
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("done_reached", 32'(done), 32'd1);
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_done",        32'(done),        32'd0);
    check("rst_pass_count",  32'(pass_count),  32'd0);
    check("rst_fail_valid",  32'(fail_valid),  32'd0);
    check("rst_cycle_count", 32'(cycle_count), 32'd0);
    check("rst_timed_out",   32'(timed_out),   32'd0);

    // All three checkpoints match
    load_std();
    fill_linear();
    run_seq(9, 1'b1);
    wait_done();
    check("t1_pass_count",  32'(pass_count),  32'd3);
    check("t1_all_pass",    32'(all_pass),    32'd1);
    check("t1_fail_valid",  32'(fail_valid),  32'd0);
    check("t1_timed_out",   32'(timed_out),   32'd0);
    check("t1_cycle_count", 32'(cycle_count), 32'd8);

    // Restart from DONE reuses the table with fresh statuses
    run_seq(9, 1'b1);
    wait_done();
    check("t1b_pass_count", 32'(pass_count), 32'd3);
    check("t1b_busy",       32'(busy),       32'd0);

    // Wrong value at checkpoint 1
    do_reset();
    load_std();
    fill_linear();
    seq_op[5] = 16'h00FF;
    run_seq(9, 1'b1);
    wait_done();
    check("t2_fail_valid", 32'(fail_valid), 32'd1);
    check("t2_fail_idx",   32'(fail_idx),   32'd1);
    check("t2_fail_value", 32'(fail_value), 32'h00FF);
    check("t2_all_pass",   32'(all_pass),   32'd0);
`ifdef CPU_TEST_MONITOR_STOP_ON_FAIL_EN
    check("t2_pass_count",  32'(pass_count),  32'd1);
    check("t2_cycle_count", 32'(cycle_count), 32'd5);
`else
    check("t2_pass_count",  32'(pass_count),  32'd2);
    check("t2_cycle_count", 32'(cycle_count), 32'd8);
`endif

    // Skip checkpoint 1 entirely (4 -> 6)
    do_reset();
    load_std();
    for (int i = 0; i < 5; i++) begin
      seq_ni[i] = WORD_SIZE'(i);
      seq_op[i] = ans_for(i);
    end
    for (int i = 5; i < 8; i++) begin
      seq_ni[i] = WORD_SIZE'(i + 1);
      seq_op[i] = ans_for(i + 1);
    end
    run_seq(8, 1'b1);
    wait_done();
    check("t3_pass_count",  32'(pass_count),  32'd2);
    check("t3_fail_valid",  32'(fail_valid),  32'd0);
    check("t3_cycle_count", 32'(cycle_count), 32'd7);

    // Timeout: never halt, never hit a checkpoint
    do_reset();
    load_std();
    @(negedge clk);
    start = 1'b1; num_inst = '0; output_port = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    check("t4_done_early", 32'(done), 32'd0);
    check("t4_busy_scan",  32'(busy), 32'd1);
    @(negedge clk);
    check("t4_done",        32'(done),        32'd1);
    check("t4_timed_out",   32'(timed_out),   32'd1);
    check("t4_cycle_count", 32'(cycle_count), 32'd19);
    check("t4_pass_count",  32'(pass_count),  32'd0);

    // Reset in the middle of a run after entry 0 has failed
    do_reset();
    load_std();
    fill_linear();
    seq_op[3] = 16'h0055;
    run_seq(5, 1'b0);
    check("t5_pre_fail_valid", 32'(fail_valid), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_busy",        32'(busy),        32'd0);
    check("t5_fail_valid",  32'(fail_valid),  32'd0);
    check("t5_fail_value",  32'(fail_value),  32'd0);
    check("t5_cycle_count", 32'(cycle_count), 32'd0);
    check("t5_done",        32'(done),        32'd0);
    reset_n = 1'b1;
    load_std();
    fill_linear();
    run_seq(9, 1'b1);
    wait_done();
    check("t5_pass_count", 32'(pass_count), 32'd3);
    check("t5_all_pass",   32'(all_pass),   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
